mreq_bus_master: RTL
====================

Name: mreq_bus_master

Overview:
- Executes one MREQ (memory request) at a time as a series of single-word bus cycles.
- Write requests: assembles little-endian words from the host write-data byte stream.
- Read requests: serialises bus read data little-endian onto the host read-data byte stream.
- Sits between the command receiver's MREQ output and the on-chip register/memory bus; it is the only bus master on that bus.

Parameters:
- TIMEOUT_CYCLES, 255, cycles to wait for i_bus_ack before aborting a bus cycle (used only with the optional feature).

Ports:
- clk  in  1  clock, posedge
- rst  in  1  reset, synchronous, active-high
- i_mreq_valid  in  1  MREQ offered
- o_mreq_ready  out  1  MREQ accepted when valid&&ready
- i_mreq  in  MREQ_NBIT  packed request {wr, aincr, wsize[1:0], wcount[7:0], addr[31:0]}
- i_wdata  in  8  write-data byte
- i_wdata_valid  in  1  write byte offered
- o_wdata_ready  out  1  write byte accepted when valid&&ready
- o_rdata  out  8  read-data byte
- o_rdata_valid  out  1  read byte offered
- i_rdata_ready  in  1  read byte accepted when valid&&ready
- o_bus_cyc  out  1  bus cycle active (equals o_bus_stb)
- o_bus_stb  out  1  strobe
- o_bus_we  out  1  1 = write
- o_bus_adr  out  32  word address
- o_bus_dat  out  32  write data, right-aligned
- o_bus_sel  out  4  byte lanes: 0001 for wsize=0, 0011 for wsize=1, 1111 for wsize=2
- i_bus_dat  in  32  read data, right-aligned
- i_bus_ack  in  1  cycle complete
- o_busy  out  1  high in every state except IDLE
- o_err_wsize  out  1  one-cycle pulse when a request with wsize=3 is rejected
- o_err_timeout  out  1  one-cycle pulse on bus timeout (tied 0 without the optional feature)

Behaviour:
- Reset values: all valid/stb/cyc/we/err outputs 0; o_mreq_ready=1; o_bus_adr, o_bus_dat and o_bus_sel are 0; state IDLE.
- Field rules:
  - Word size in bytes is nbytes = 1 << wsize.
  - Word count is wcount+1, giving 1..256 words.
  - addr is a word address. After each word, addr increments by 1 if aincr=1, otherwise it is held.
  - addr wraps 0xFFFFFFFF -> 0x00000000.
- IDLE:
  - o_mreq_ready=1.
  - On accept, latch all fields and set word counter = wcount and byte index = 0.
  - wsize=3: pulse o_err_wsize on the next cycle, issue no bus cycle, stay in IDLE.
  - Otherwise, wr=1 -> COLLECT; wr=0 -> BUS.
- COLLECT:
  - o_wdata_ready=1.
  - Each accepted byte is stored at lane [8*idx +: 8] and idx increments.
  - The byte accepted with idx = nbytes-1 completes the word -> BUS; unused lanes of o_bus_dat are 0.
- BUS:
  - stb=cyc=1, we=wr, adr/dat/sel stable until ack.
  - On i_bus_ack, stb drops on the next edge (no back-to-back strobes without an intervening state).
  - Read: capture i_bus_dat, idx=0 -> EMIT.
  - Write, not last word: update addr, decrement counter, idx=0 -> COLLECT.
  - Write, last word (counter=0): -> IDLE.
- EMIT:
  - o_rdata_valid=1, o_rdata = captured[8*idx +: 8]; the value is held while valid && !ready.
  - Each accept increments idx.
  - Accept at idx = nbytes-1: last word -> IDLE; otherwise update addr, decrement counter -> BUS.
- Latency:
  - Read: strobe is asserted in the cycle after MREQ accept.
  - Write: strobe is asserted in the cycle after the last byte of the word is accepted.
  - The first read byte is valid in the cycle after ack.
- o_mreq_ready is 0 outside IDLE, so a new MREQ is accepted only after the final word completes (ack for writes, last byte accepted for reads).
- Bytes presented on i_wdata while not in COLLECT are not consumed.
- Reset mid-operation: at the next edge, cyc/stb/valid drop and partially assembled data is discarded. An outstanding ack arriving after reset is ignored.

Optional Feature:
- Macro: MREQ_BUS_TIMEOUT_EN.
- With the macro defined:
  - A counter runs while in BUS. Reaching TIMEOUT_CYCLES without ack aborts the cycle as if acked and pulses o_err_timeout.
  - Aborted reads return 0x00000000.
  - The sequence continues normally afterwards.
- Without the macro: BUS waits for ack indefinitely, and o_err_timeout is constant 0.

Decomposition:
- mreq_defines.vh:
  - MREQ_NBIT and the pack_mreq/unpack field extraction.
  - The state encoding for this block (IDLE, COLLECT, BUS, EMIT).
  - Helper functions for nbytes and sel derived from wsize.
- No sub-module; the byte lane packer/unpacker stays inline.

Test Plan:
- Write, wsize=2, wcount=1, aincr=1, addr=0x10, bytes 11 22 33 44 55 66 77 88 -> two writes: adr 0x10 dat 0x44332211 sel 1111, then adr 0x11 dat 0x88776655; then o_mreq_ready=1.
- Read, wsize=1, wcount=2, aincr=0, addr=0x20, bus returns 0xBEEF, 0x1234, 0xCAFE -> three reads all at adr 0x20, sel 0011; bytes EF BE 34 12 FE CA, with stalls from i_rdata_ready=0 holding the byte.
- Read, wsize=0, aincr=1, addr=0xFFFFFFFF, wcount=1 -> adr 0xFFFFFFFF then 0x00000000, sel 0001.
- MREQ with wsize=3 -> o_err_wsize pulses once, no o_bus_stb, next MREQ accepted normally.
- rst asserted while stb=1 waiting for ack -> stb and cyc=0 next cycle, IDLE, a late ack is ignored, and a following read completes correctly.
- With MREQ_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, ack never asserted, read wsize=2 -> abort after 8 cycles, o_err_timeout pulses, bytes 00 00 00 00 emitted.

Source files
------------

// File: rtl/mreq_bus_master_pkg.sv
// Shared types and helpers for the MREQ bus master: request packing, FSM states,
// and per-word-size byte count / lane select derivation.
package mreq_bus_master_pkg;

  localparam int MREQ_NBIT = 44;

  typedef struct packed {
    logic        wr;
    logic        aincr;
    logic [1:0]  wsize;
    logic [7:0]  wcount;
    logic [31:0] addr;
  } mreq_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    BUS     = 2'd2,
    EMIT    = 2'd3
  } state_t;

  function automatic logic [MREQ_NBIT-1:0] pack_mreq(input logic        wr,
                                                     input logic        aincr,
                                                     input logic [1:0]  wsize,
                                                     input logic [7:0]  wcount,
                                                     input logic [31:0] addr);
    return {wr, aincr, wsize, wcount, addr};
  endfunction

  function automatic mreq_t unpack_mreq(input logic [MREQ_NBIT-1:0] raw);
    return mreq_t'(raw);
  endfunction

  // wsize=3 is illegal and never reaches a data path, so its value here is irrelevant
  function automatic logic [2:0] nbytes(input logic [1:0] wsize);
    case (wsize)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [1:0] lastIdx(input logic [1:0] wsize);
    logic [2:0] n;
    n = nbytes(wsize) - 3'd1;
    return n[1:0];
  endfunction

  function automatic logic [3:0] selOf(input logic [1:0] wsize);
    case (wsize)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      2'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mreq_bus_master_if.sv
// Host-side MREQ / byte-stream handshakes plus the register bus, grouped for the
// bus master (master modport) and its environment (slave modport).
interface mreq_bus_master_if;
  import mreq_bus_master_pkg::*;

  logic                 i_mreq_valid;
  logic                 o_mreq_ready;
  logic [MREQ_NBIT-1:0] i_mreq;
  logic [7:0]           i_wdata;
  logic                 i_wdata_valid;
  logic                 o_wdata_ready;
  logic [7:0]           o_rdata;
  logic                 o_rdata_valid;
  logic                 i_rdata_ready;
  logic                 o_bus_cyc;
  logic                 o_bus_stb;
  logic                 o_bus_we;
  logic [31:0]          o_bus_adr;
  logic [31:0]          o_bus_dat;
  logic [3:0]           o_bus_sel;
  logic [31:0]          i_bus_dat;
  logic                 i_bus_ack;
  logic                 o_busy;
  logic                 o_err_wsize;
  logic                 o_err_timeout;

  modport master (
    input  i_mreq_valid, i_mreq, i_wdata, i_wdata_valid, i_rdata_ready,
    input  i_bus_dat, i_bus_ack,
    output o_mreq_ready, o_wdata_ready, o_rdata, o_rdata_valid,
    output o_bus_cyc, o_bus_stb, o_bus_we, o_bus_adr, o_bus_dat, o_bus_sel,
    output o_busy, o_err_wsize, o_err_timeout
  );

  modport slave (
    output i_mreq_valid, i_mreq, i_wdata, i_wdata_valid, i_rdata_ready,
    output i_bus_dat, i_bus_ack,
    input  o_mreq_ready, o_wdata_ready, o_rdata, o_rdata_valid,
    input  o_bus_cyc, o_bus_stb, o_bus_we, o_bus_adr, o_bus_dat, o_bus_sel,
    input  o_busy, o_err_wsize, o_err_timeout
  );

endinterface

// File: rtl/mreq_bus_master.sv
// Executes one MREQ at a time as single-word bus cycles, packing/unpacking bytes
// little-endian. Define MREQ_BUS_TIMEOUT_EN to abort unacknowledged bus cycles.
module mreq_bus_master
  import mreq_bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  mreq_bus_master_if.master    bus
);

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic        aincr_q, aincr_d;
  logic [1:0]  wsize_q, wsize_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rdat_q, rdat_d;
  logic        errWsize_q, errWsize_d;
  logic        errTimeout;
  logic        timedOut;

  logic        mreqReady, wdataReady, busStb, rdataValid;
  logic [31:0] addrNext;
  logic        lastByte;
  mreq_t       req;

  assign req      = unpack_mreq(bus.i_mreq);
  assign addrNext = aincr_q ? addr_q + 32'd1 : addr_q;
  assign lastByte = (idx_q == lastIdx(wsize_q));

`ifdef MREQ_BUS_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        errTimeout_q;

  assign timedOut = (state_q == BUS) && !bus.i_bus_ack &&
                    (tmo_q == 32'(TIMEOUT_CYCLES - 1));
  assign tmo_d    = ((state_q == BUS) && !bus.i_bus_ack && !timedOut) ? tmo_q + 32'd1 : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q        <= 32'd0;
      errTimeout_q <= 1'b0;
    end else begin
      tmo_q        <= tmo_d;
      errTimeout_q <= timedOut;
    end
  end

  assign errTimeout = errTimeout_q;
`else
  logic unusedTimeoutCfg;
  assign unusedTimeoutCfg = ^TIMEOUT_CYCLES;
  assign timedOut         = 1'b0;
  assign errTimeout       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      aincr_q    <= 1'b0;
      wsize_q    <= 2'd0;
      cnt_q      <= 8'd0;
      idx_q      <= 2'd0;
      addr_q     <= 32'd0;
      sel_q      <= 4'd0;
      wdat_q     <= 32'd0;
      rdat_q     <= 32'd0;
      errWsize_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      aincr_q    <= aincr_d;
      wsize_q    <= wsize_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      wdat_q     <= wdat_d;
      rdat_q     <= rdat_d;
      errWsize_q <= errWsize_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    aincr_d    = aincr_q;
    wsize_d    = wsize_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    wdat_d     = wdat_q;
    rdat_d     = rdat_q;
    errWsize_d = 1'b0;
    mreqReady  = 1'b0;
    wdataReady = 1'b0;
    busStb     = 1'b0;
    rdataValid = 1'b0;

    case (state_q)
      IDLE: begin
        mreqReady = 1'b1;
        if (bus.i_mreq_valid) begin
          wr_d    = req.wr;
          aincr_d = req.aincr;
          wsize_d = req.wsize;
          cnt_d   = req.wcount;
          idx_d   = 2'd0;
          addr_d  = req.addr;
          sel_d   = selOf(req.wsize);
          wdat_d  = 32'd0;
          if (req.wsize == 2'd3) begin
            errWsize_d = 1'b1;
          end else begin
            state_d = req.wr ? COLLECT : BUS;
          end
        end
      end

      COLLECT: begin
        wdataReady = 1'b1;
        if (bus.i_wdata_valid) begin
          wdat_d[{idx_q, 3'b000} +: 8] = bus.i_wdata;
          if (lastByte) begin
            idx_d   = 2'd0;
            state_d = BUS;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      BUS: begin
        busStb = 1'b1;
        // A timeout completes the cycle exactly like an ack, but reads return zero
        if (bus.i_bus_ack || timedOut) begin
          idx_d = 2'd0;
          if (!wr_q) begin
            rdat_d  = bus.i_bus_ack ? bus.i_bus_dat : 32'd0;
            state_d = EMIT;
          end else if (cnt_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            addr_d  = addrNext;
            cnt_d   = cnt_q - 8'd1;
            wdat_d  = 32'd0;
            state_d = COLLECT;
          end
        end
      end

      EMIT: begin
        rdataValid = 1'b1;
        if (bus.i_rdata_ready) begin
          if (!lastByte) begin
            idx_d = idx_q + 2'd1;
          end else if (cnt_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            idx_d   = 2'd0;
            addr_d  = addrNext;
            cnt_d   = cnt_q - 8'd1;
            state_d = BUS;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.o_mreq_ready  = mreqReady;
  assign bus.o_wdata_ready = wdataReady;
  assign bus.o_rdata       = rdat_q[{idx_q, 3'b000} +: 8];
  assign bus.o_rdata_valid = rdataValid;
  assign bus.o_bus_cyc     = busStb;
  assign bus.o_bus_stb     = busStb;
  assign bus.o_bus_we      = busStb & wr_q;
  assign bus.o_bus_adr     = addr_q;
  assign bus.o_bus_dat     = wdat_q;
  assign bus.o_bus_sel     = sel_q;
  assign bus.o_busy        = (state_q != IDLE);
  assign bus.o_err_wsize   = errWsize_q;
  assign bus.o_err_timeout = errTimeout;

endmodule
